// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide, one bit per clock, with sign fix-up and direct HI/LO writes.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, op, a, b   launch: op 00 mult, 01 multu, 10 div, 11 divu
//   wr_hi, wr_lo, wd  direct write of HI/LO while idle (mthi/mtlo)
//   busy, done, dbz   status: in progress, result pulse, divide-by-zero
//   hi, lo            architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               zero_div;
    // opnd: multiplicand (mult) or divisor (div)
    // mq:   multiplier shifting out / low product bits, or dividend / quotient
    // acc:  high product bits, or partial remainder
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               dbz_r;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_t;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign mul_sum = {1'b0, acc} + {1'b0, opnd};
    assign mul_t   = mq[0] ? mul_sum : {1'b0, acc};

    // Partial remainder stays below the divisor, so bit WIDTH of the
    // difference is set only on a borrow.
    assign div_sh   = {acc, mq[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_ge   = ~div_diff[WIDTH];

    assign prod     = {acc, mq};
    assign prod_fix = neg_q ? -prod : prod;
    // With a zero divisor every trial subtract succeeds, leaving the
    // dividend in the remainder; only the quotient needs forcing.
    assign quo_fix  = zero_div ? '1 : (neg_q ? -mq : mq);
    assign rem_fix  = neg_r ? -acc : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            opnd     <= '0;
            mq       <= '0;
            acc      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= op[1] & a_neg;
                        zero_div <= op[1] & (b == '0);
                        opnd     <= op[1] ? b_mag : a_mag;
                        mq       <= op[1] ? a_mag : b_mag;
                        acc      <= '0;
                        cnt      <= CW'(WIDTH);
                    end else begin
                        if (wr_hi) begin
                            hi_r <= wd;
                        end
                        if (wr_lo) begin
                            lo_r <= wd;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= div_ge ? div_diff[WIDTH-1:0]
                                      : div_sh[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_t[WIDTH:1];
                        mq  <= {mul_t[0], mq[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    done_r <= 1'b1;
                    dbz_r  <= zero_div;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_r;
    assign dbz  = dbz_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus hand sequences,
// results checked through an expected-result queue when done pulses.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wd;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           id;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] last_hi;
    logic [W-1:0] last_lo;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("hi[%0d]", e.id), hi, e.hi);
                    chk($sformatf("lo[%0d]", e.id), lo, e.lo);
                    chk($sformatf("dbz[%0d]", e.id), dbz, e.dbz);
                end
            end else begin
                chk("dbz_not_done", dbz, 0);
            end
        end
    end

    task automatic launch(input logic [1:0] t_op, input logic [W-1:0] t_a,
                          input logic [W-1:0] t_b, input logic [W-1:0] t_hi,
                          input logic [W-1:0] t_lo, input logic t_dbz,
                          input int id);
        exp_t e;
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        e.hi  = t_hi;
        e.lo  = t_lo;
        e.dbz = t_dbz;
        e.id  = id;
        sb.push_back(e);
        last_hi = t_hi;
        last_lo = t_lo;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t_op, input logic [W-1:0] t_a,
                         input logic [W-1:0] t_b, input logic [W-1:0] t_hi,
                         input logic [W-1:0] t_lo, input logic t_dbz,
                         input int id);
        @(negedge clk);
        launch(t_op, t_a, t_b, t_hi, t_lo, t_dbz, id);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
        end
        if (!done) begin
            chk(name, 0, 1);
        end
    endtask

    initial begin
        vec_t         vt[16];
        int           lat;
        logic         seen;
        logic         bsy_ok;
        logic         hold_ok;
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;

        vt[0]  = '{2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0};
        vt[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0};
        vt[4]  = '{2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
        vt[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
        vt[6]  = '{2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
        vt[7]  = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0};
        vt[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0};
        vt[9]  = '{2'd1, 32'h80000000, 32'd2, 32'd1, 32'h0, 1'b0};
        vt[10] = '{2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vt[11] = '{2'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vt[12] = '{2'd3, 32'hFFFFFFFF, 32'hA, 32'd5, 32'h19999999, 1'b0};
        vt[13] = '{2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 1'b0};
        vt[14] = '{2'd2, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0, 1'b0};
        vt[15] = '{2'd1, 32'h12345678, 32'h10, 32'd1, 32'h23456780, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        op = 2'd0;
        a = '0;
        b = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wd = '0;
        last_hi = '0;
        last_lo = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        // Start on the very first edge after reset release; measure latency.
        @(negedge clk);
        rst = 1'b0;
        launch(2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
        lat = 0;
        seen = 1'b0;
        bsy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!seen && lat < 60) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) bsy_ok = 1'b0;
                if (hi !== '0 || lo !== '0) hold_ok = 1'b0;
                @(posedge clk);
                lat++;
            end
        end
        chk("latency", lat, 33);
        chk("busy_during_op", bsy_ok, 1);
        chk("hilo_held", hold_ok, 1);
        chk("busy_at_done", busy, 0);
        wait_idle();

        // Back-to-back: next start driven in the done cycle.
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 1);
        wait_done("b2b_done1");
        launch(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 2);
        wait_done("b2b_done2");
        launch(2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 3);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
                  vt[i].dbz, 10 + i);
            wait_idle();
        end

        // start and wr_lo while busy must be ignored.
        prev_hi = last_hi;
        prev_lo = last_lo;
        issue(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 40);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = 2'd1;
        a = 32'd3;
        b = 32'd3;
        wr_lo = 1'b1;
        wd = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_lo = 1'b0;
        @(negedge clk);
        chk("busy_wr_lo", lo, prev_lo);
        chk("busy_hi_held", hi, prev_hi);
        wait_idle();
        repeat (40) @(negedge clk);

        // Direct writes while idle.
        @(negedge clk);
        wr_hi = 1'b1;
        wd = 32'h12345678;
        @(posedge clk);
        #1 wr_hi = 1'b0;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, last_lo);
        chk("mthi_done", done, 0);
        chk("mthi_dbz", dbz, 0);

        @(negedge clk);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wd = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        @(negedge clk);
        chk("mthilo_hi", hi, 32'hA5A5A5A5);
        chk("mthilo_lo", lo, 32'hA5A5A5A5);
        chk("mthilo_done", done, 0);

        // Write together with start is dropped; the operation proceeds.
        @(negedge clk);
        wr_hi = 1'b1;
        wd = 32'hCAFEF00D;
        launch(2'd3, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 41);
        wr_hi = 1'b0;
        @(negedge clk);
        chk("mthi_with_start", hi, 32'hA5A5A5A5);
        wait_idle();

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1;
        op = 2'd2;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_dbz", dbz, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        launch(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 42);
        wait_idle();
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are 2 or more.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  2  operation: 00 mult signed, 01 multu, 10 div signed, 11 divu.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port wr_hi  input  1  direct write of HI (mthi).
REQ-009 SHALL have port wr_lo  input  1  direct write of LO (mtlo).
REQ-010 SHALL have port wd  input  WIDTH  data for wr_hi and wr_lo.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-013 SHALL have port dbz  output  1  divide-by-zero flag, valid while done is high.
REQ-014 SHALL have port hi  output  WIDTH  HI register.
REQ-015 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-016 SHALL implement states IDLE, CALC and FIX; busy SHALL be 1 exactly when the state is not IDLE.
REQ-017 SHALL, in IDLE with start=1 at an edge (E0), latch op, operand magnitudes (signed ops) or raw operands (unsigned ops), and the result signs; load an iteration counter with WIDTH; and enter CALC.
REQ-018 SHALL perform one iteration per edge in CALC:
 - multiply: shift-add, one multiplier bit per edge.
 - divide: restoring, one quotient bit per edge.
 - Counter decrements each edge; CALC is left for FIX at edge E(WIDTH).
REQ-019 SHALL, at edge E(WIDTH+1) in FIX:
 - apply sign correction and write hi/lo;
 - set done=1 for exactly one cycle;
 - return to IDLE.
 Total latency is WIDTH+1 cycles from the start edge to done high.
REQ-020 SHALL write multiply results as {hi,lo} = full 2*WIDTH-bit product; the signed product SHALL be two's-complement negated when the operand signs differ.
REQ-021 SHALL write divide results as lo = quotient truncated toward zero and hi = remainder; signed remainder SHALL take the sign of the dividend.
REQ-022 SHALL, for signed most-negative / -1, produce lo = most-negative value and hi = 0, with no flag.
REQ-023 SHALL, for divide with b=0, produce lo = all ones, hi = a unmodified, and dbz=1 during the done cycle; latency is unchanged.
REQ-024 SHALL hold dbz at 0 whenever done is 0 and for every multiply.
REQ-025 SHALL ignore start while busy=1; the in-flight operation SHALL be unaffected.
REQ-026 SHALL allow back-to-back operation: start sampled in the done cycle (state IDLE) begins a new operation.
REQ-027 SHALL apply wr_hi/wr_lo only in IDLE with start=0; wr_hi and wr_lo together SHALL write wd to both registers; writes SHALL be ignored while busy or when start=1.
REQ-028 SHALL leave hi/lo unchanged from E0 until E(WIDTH+1); intermediate values SHALL be held in internal registers.
REQ-029 SHALL keep done and dbz at 0 after a direct write.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-operation, immediately force state=IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, and clear the counter and internal registers.
REQ-031 SHALL accept start on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-032 SHALL cover: mult a=0xFFFFFFFD (-3), b=7 -> done 33 cycles after the start edge, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1..33.
REQ-033 SHALL cover: multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then back-to-back div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1.
REQ-034 SHALL cover: divu a=5, b=0 -> lo=0xFFFFFFFF, hi=5, dbz=1 during the done cycle only; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-035 SHALL cover: start pulsed at cycle 5 of a busy multiply with different operands -> first result unchanged, no second done; wr_lo=1 while busy -> lo unchanged.
REQ-036 SHALL cover: idle, wr_hi=1, wd=0x12345678 -> hi=0x12345678 next edge, done=0; wr_hi with start=1 -> write dropped.
REQ-037 SHALL cover: rst asserted at cycle 10 of a divide -> all outputs 0 immediately, no done; a new mult 6*7 after release -> lo=42, hi=0.
